// File: rtl/poly_add_seq_if.sv
// poly_add_seq_if: operand, result and handshake bundle for poly_add_seq
interface poly_add_seq_if #(
    parameter int N     = 256,
    parameter int K     = 3,
    parameter int ETA_W = 3
);
    logic                         start;
    logic                         en;
    logic                         sub;
    logic [K-1:0][N*16-1:0]       x;
    logic [N*16-1:0]              y;
    logic [K-1:0][N*ETA_W-1:0]    e_1;
    logic [N*ETA_W-1:0]           e_2;
    logic [N*16-1:0]              poly_msg;
    logic [K-1:0][N*16-1:0]       u;
    logic [N*16-1:0]              v;
    logic                         busy;
    logic                         done;
    modport master (output start, en, sub, x, y, e_1, e_2, poly_msg, input u, v, busy, done);
    modport slave  (input start, en, sub, x, y, e_1, e_2, poly_msg, output u, v, busy, done);
endinterface

// File: rtl/poly_add_seq.sv
// poly_add_seq: chunked modular add/subtract of noise and message into K+1 polynomials
module poly_add_seq #(
    parameter int N     = 256,
    parameter int K     = 3,
    parameter int Q     = 3329,
    parameter int LANES = 16,
    parameter int ETA_W = 3
) (
    input logic          clk,
    input logic          rst,
    poly_add_seq_if.slave bus
);
    localparam int CH = N / LANES;
    localparam int IW = CH > 1 ? $clog2(CH) : 1;
    localparam int SW = 20;
    localparam logic [IW-1:0] LAST = IW'(CH - 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic signed [SW-1:0] Q1 = SW'(Q), Q2 = SW'(2 * Q), NQ = -SW'(Q);

    logic [1:0]                   state;
    logic [IW-1:0]                idx;
    logic [31:0]                  base;
    logic [K-1:0][LANES-1:0][15:0] nu;
    logic [LANES-1:0][15:0]       nv;

    function automatic logic signed [SW-1:0] zx(input logic [15:0] a);
        return {{(SW-16){1'b0}}, a};
    endfunction

    function automatic logic signed [SW-1:0] sx(input logic [ETA_W-1:0] a);
        return {{(SW-ETA_W){a[ETA_W-1]}}, a};
    endfunction

    // Folds any sum in (-2Q, 3Q) back into [0, Q-1] with a single select
    function automatic logic [15:0] red(input logic signed [SW-1:0] s);
        return 16'(s < NQ ? s + Q2 : s[SW-1] ? s + Q1 : s >= Q2 ? s - Q2 : s >= Q1 ? s - Q1 : s);
    endfunction

    assign base     = 32'(idx) * LANES;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;

    always_comb begin
        nu = '0;
        nv = '0;
        for (int k = 0; k < K; k++)
            for (int l = 0; l < LANES; l++)
                nu[k][l] = red(bus.sub ? zx(bus.x[k][(base+l)*16 +: 16]) - sx(bus.e_1[k][(base+l)*ETA_W +: ETA_W])
                                       : zx(bus.x[k][(base+l)*16 +: 16]) + sx(bus.e_1[k][(base+l)*ETA_W +: ETA_W]));
        for (int l = 0; l < LANES; l++)
            nv[l] = red(bus.sub ? zx(bus.y[(base+l)*16 +: 16]) - sx(bus.e_2[(base+l)*ETA_W +: ETA_W]) - zx(bus.poly_msg[(base+l)*16 +: 16])
                                : zx(bus.y[(base+l)*16 +: 16]) + sx(bus.e_2[(base+l)*ETA_W +: ETA_W]) + zx(bus.poly_msg[(base+l)*16 +: 16]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            bus.u <= '0;
            bus.v <= '0;
        end else begin
            state <= state == IDLE ? (bus.start ? RUN : IDLE) :
                     state == RUN  ? ((bus.en && idx == LAST) ? DONE : RUN) : IDLE;
            if (state == IDLE && bus.start)
                idx <= '0;
            else if (state == RUN && bus.en) begin
                idx <= idx + IW'(1);
                for (int k = 0; k < K; k++)
                    for (int l = 0; l < LANES; l++)
                        bus.u[k][(base+l)*16 +: 16] <= nu[k][l];
                for (int l = 0; l < LANES; l++)
                    bus.v[(base+l)*16 +: 16] <= nv[l];
            end
        end
    end
endmodule

// File: tb/tb_poly_add_seq.sv
// tb_poly_add_seq: directed table-driven bench for poly_add_seq
module tb_poly_add_seq;
    localparam int N = 256, K = 3, Q = 3329, LANES = 16, ETA_W = 3;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_add_seq_if #(.N(N), .K(K), .ETA_W(ETA_W)) bus ();
    poly_add_seq #(.N(N), .K(K), .Q(Q), .LANES(LANES), .ETA_W(ETA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int x, e1, y, e2, m;
        bit sub;
        int eu, ev;
    } vec_t;

    vec_t tv[8];
    int checks = 0;
    int fails  = 0;
    int dc, bc, nd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t t);
        logic [ETA_W-1:0] a, b;
        a = t.e1[ETA_W-1:0];
        b = t.e2[ETA_W-1:0];
        bus.sub = t.sub;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < K; k++) begin
                bus.x[k][i*16 +: 16]        = 16'(t.x);
                bus.e_1[k][i*ETA_W +: ETA_W] = a;
            end
            bus.y[i*16 +: 16]        = 16'(t.y);
            bus.e_2[i*ETA_W +: ETA_W] = b;
            bus.poly_msg[i*16 +: 16] = 16'(t.m);
        end
    endtask

    task automatic check_uv(input string name, input int eu, input int ev);
        logic [31:0] au, av;
        au = eu;
        av = ev;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < K; k++)
                if (bus.u[k][i*16 +: 16] !== 16'(eu)) au = {16'b0, bus.u[k][i*16 +: 16]};
            if (bus.v[i*16 +: 16] !== 16'(ev)) av = {16'b0, bus.v[i*16 +: 16]};
        end
        chk({name, "_u"}, au, eu);
        chk({name, "_v"}, av, ev);
    endtask

    // Called at a falling edge; cycle 1 is the first cycle after the start edge
    task automatic run(input int stall_at, input int restart_at, output int d, output int b, output int n);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        d = 0;
        b = 0;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.busy === 1'b1) b++;
            if (bus.done === 1'b1) begin
                n++;
                d = c;
            end
            bus.en    = !(c >= stall_at && c < stall_at + 3);
            bus.start = c == restart_at;
            @(negedge clk);
        end
        bus.en    = 1'b1;
        bus.start = 1'b0;
    endtask

    initial begin
        tv[0] = '{x: 0,    e1: 1,  y: 0,    e2: 0,  m: 0,    sub: 0, eu: 1,    ev: 0};
        tv[1] = '{x: 3328, e1: 2,  y: 3328, e2: 2,  m: 1665, sub: 0, eu: 1,    ev: 1666};
        tv[2] = '{x: 0,    e1: -2, y: 0,    e2: 0,  m: 0,    sub: 0, eu: 3327, ev: 0};
        tv[3] = '{x: 0,    e1: 2,  y: 0,    e2: 0,  m: 1665, sub: 1, eu: 3327, ev: 1664};
        tv[4] = '{x: 5,    e1: -3, y: 3328, e2: -4, m: 1665, sub: 1, eu: 8,    ev: 1667};
        tv[5] = '{x: 3328, e1: 3,  y: 3328, e2: 3,  m: 1665, sub: 0, eu: 2,    ev: 1667};
        tv[6] = '{x: 0,    e1: 3,  y: 0,    e2: 3,  m: 1665, sub: 1, eu: 3326, ev: 1661};
        tv[7] = '{x: 100,  e1: -4, y: 0,    e2: -4, m: 0,    sub: 0, eu: 96,   ev: 3325};
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.en    = 1'b1;
        load(tv[0]);
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, bus.busy}, 0);
        chk("reset_done", {31'b0, bus.done}, 0);
        check_uv("reset", 0, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            load(tv[t]);
            run(100, 100, dc, bc, nd);
            chk($sformatf("vec%0d_done_cycle", t), dc, 17);
            chk($sformatf("vec%0d_busy_cycles", t), bc, 17);
            chk($sformatf("vec%0d_done_count", t), nd, 1);
            check_uv($sformatf("vec%0d", t), tv[t].eu, tv[t].ev);
        end

        load(tv[5]);
        run(5, 100, dc, bc, nd);
        chk("stall_done_cycle", dc, 20);
        chk("stall_busy_cycles", bc, 20);
        chk("stall_done_count", nd, 1);
        check_uv("stall", tv[5].eu, tv[5].ev);

        load(tv[0]);
        run(100, 5, dc, bc, nd);
        chk("restart_done_cycle", dc, 17);
        chk("restart_done_count", nd, 1);
        check_uv("restart", tv[0].eu, tv[0].ev);

        load(tv[2]);
        repeat (3) @(negedge clk);
        check_uv("hold_idle", tv[0].eu, tv[0].ev);

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_lane0", {16'b0, bus.u[0][15:0]}, tv[2].eu);
        chk("partial_lane_untouched", {16'b0, bus.u[K-1][2*LANES*16 +: 16]}, tv[0].eu);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, bus.busy}, 0);
        chk("midrst_done", {31'b0, bus.done}, 0);
        check_uv("midrst", 0, 0);
        rst = 1'b0;
        run(100, 100, dc, bc, nd);
        chk("after_rst_done_cycle", dc, 17);
        chk("after_rst_done_count", nd, 1);
        check_uv("after_rst", tv[2].eu, tv[2].ev);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/poly_add_seq.md
POLY_ADD_SEQ -- requirements
Module: poly_add_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk drives all state; rst is sampled only on the rising edge of clk.
REQ-002 Parameter N, default 256: coefficients per polynomial.
REQ-003 Parameter K, default 3: vector rank, i.e. number of u channels; legal values are 2, 3 and 4.
REQ-004 Parameter Q, default 3329: the modulus.
REQ-005 Parameter LANES, default 16: coefficients processed per cycle; it SHALL divide N.
REQ-006 Parameter ETA_W, default 3: width of each signed noise coefficient.
REQ-007 Ports: clk, input, 1 bit, clock.
REQ-008 Ports: rst, input, 1 bit, synchronous active-high reset.
REQ-009 Ports: start, input, 1 bit, one-cycle request to begin an operation.
REQ-010 Ports: en, input, 1 bit, advance enable; when low, the block stalls.
REQ-011 Ports: sub, input, 1 bit, mode select; 0 = add, 1 = subtract.
REQ-012 Ports: x, input, K x (N*16) bits, vector polynomial; 16-bit fields, value in [0,Q-1].
REQ-013 Ports: y, input, N*16 bits, scalar polynomial, same format as x.
REQ-014 Ports: e_1, input, K x (N*ETA_W) bits, signed noise vector.
REQ-015 Ports: e_2, input, N*ETA_W bits, signed noise polynomial.
REQ-016 Ports: poly_msg, input, N*16 bits, message polynomial; each field is 0 or (Q+1)/2.
REQ-017 Ports: u, output, K x (N*16) bits, registered result vector.
REQ-018 Ports: v, output, N*16 bits, registered scalar result.
REQ-019 Ports: busy, output, 1 bit, high while an operation is in progress.
REQ-020 Ports: done, output, 1 bit, one-cycle pulse when an operation completes.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-022 Transition IDLE->RUN occurs on start=1; the chunk index idx is cleared to 0.
REQ-023 In RUN with en=1, the block SHALL write lanes idx*LANES .. idx*LANES+LANES-1 of every u channel and of v, then increment idx.
REQ-024 In RUN with en=0, idx, u and v SHALL hold.
REQ-025 When idx = N/LANES-1 and en=1, the next state SHALL be DONE.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-028 With no stalls, done SHALL be high in cycle N/LANES+1 after the start edge (cycle 17 at default parameters).
REQ-029 start SHALL be ignored in RUN and DONE; it is honoured only in IDLE.
REQ-030 x, y, e_1, e_2, poly_msg and sub are read combinationally at each RUN cycle; the source SHALL hold them stable from start until done.
REQ-031 Arithmetic, sub=0: u[k][i] = (x[k][i] + e_1[k][i]) mod Q; v[i] = (y[i] + e_2[i] + poly_msg[i]) mod Q.
REQ-032 Arithmetic, sub=1: u[k][i] = (x[k][i] - e_1[k][i]) mod Q; v[i] = (y[i] - e_2[i] - poly_msg[i]) mod Q.
REQ-033 Noise values SHALL be sign-extended two's complement.
REQ-034 Intermediate sums SHALL be carried with no truncation.
REQ-035 Every result SHALL be fully reduced to [0,Q-1], including negative sums and sums up to 2Q+2^(ETA_W-1), and stored zero-extended in its 16-bit field.
REQ-036 Lanes not yet processed in the current operation SHALL retain their previous contents.
REQ-037 u and v SHALL remain stable after done until the next RUN writes them.

Reset
REQ-038 With rst=1 on a rising edge: state = IDLE, idx = 0, busy = 0, done = 0, and all u and v fields = 0.
REQ-039 rst SHALL take priority over start and en.
REQ-040 Reset during RUN or DONE SHALL abort the operation with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted.

Verification
REQ-041 The bench SHALL cover: x = 0, e_1 = +1, y = 0, e_2 = 0, poly_msg = 0, sub = 0 -> every u field = 1, v = 0, done high at cycle 17, busy high for cycles 1-17.
REQ-042 The bench SHALL cover wrap-around: x = 3328, e_1 = +2; y = 3328, e_2 = +2, poly_msg = 1665 -> u = 1, v = 1666.
REQ-043 The bench SHALL cover negative results: x = 0, e_1 = -2, sub = 0 -> u = 3327; x = 0, e_1 = +2, sub = 1 -> u = 3327; y = 0, e_2 = 0, poly_msg = 1665, sub = 1 -> v = 1664.
REQ-044 The bench SHALL cover stall: en low for 3 cycles during RUN -> done at cycle 20, results identical to the unstalled run.
REQ-045 The bench SHALL cover ignored start: start pulsed again at cycle 5 -> no restart, a single done at cycle 17.
REQ-046 The bench SHALL cover mid-operation reset: rst at cycle 6 -> busy = 0, u = v = 0, no done; a fresh start then completes normally at cycle 17.
